// File: rtl/latch_write_sched_pkg.sv
// Shared types and helpers for the latch write scheduler.
// Holds the FSM state encoding and the phase-counter sizing function.
package latch_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    VERIFY,
    ACK
  } state_t;

  // Wide enough to hold the longest phase length minus one.
  function automatic int cnt_width(input int s, input int p, input int h);
    int m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/latch_write_sched_if.sv
// Requester and latch-bank signals of the write scheduler; slave is the scheduler side.
// LATCH_SCHED_READBACK_EN adds the readback path (lat_q, lat_raddr, err).
interface latch_sched_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [1:0]        req;
  logic [ADDR_W-1:0] req0_addr;
  logic [WIDTH-1:0]  req0_data;
  logic [ADDR_W-1:0] req1_addr;
  logic [WIDTH-1:0]  req1_data;
  logic [1:0]        ack;
  logic              busy;
  logic [WIDTH-1:0]  lat_d;
  logic [DEPTH-1:0]  lat_en;
`ifdef LATCH_SCHED_READBACK_EN
  logic [WIDTH-1:0]  lat_q;
  logic [ADDR_W-1:0] lat_raddr;
  logic              err;

  modport master (
    output req, req0_addr, req0_data, req1_addr, req1_data, lat_q,
    input  ack, busy, lat_d, lat_en, lat_raddr, err
  );
  modport slave (
    input  req, req0_addr, req0_data, req1_addr, req1_data, lat_q,
    output ack, busy, lat_d, lat_en, lat_raddr, err
  );
`else
  modport master (
    output req, req0_addr, req0_data, req1_addr, req1_data,
    input  ack, busy, lat_d, lat_en
  );
  modport slave (
    input  req, req0_addr, req0_data, req1_addr, req1_data,
    output ack, busy, lat_d, lat_en
  );
`endif

endinterface

// File: rtl/latch_write_sched_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational; zero latency, no backpressure.
// On a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/latch_write_sched.sv
// Timed SETUP/PULSE/HOLD write sequencer for a gated-latch bank; ack 1+SETUP+PULSE+HOLD cycles after grant.
// Requesters hold req until ack; LATCH_SCHED_READBACK_EN adds a VERIFY cycle with err on readback mismatch.
module latch_write_sched
  import latch_sched_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic           clk,
  input  logic           rst,
  latch_sched_if.slave   bus_io
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [DEPTH-1:0] EN_LSB = DEPTH'(1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  lat_d_q;
  logic [DEPTH-1:0]  lat_en_q;
  logic [1:0]        ack_q;
  logic              busy_q;
  logic              last_grant_q;
  logic              gnt_q;
`ifdef LATCH_SCHED_READBACK_EN
  logic              err_q;
`endif

  logic [1:0]        gnt_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [WIDTH-1:0]  sel_data_d;
  logic [DEPTH-1:0]  en_dec;
  logic [1:0]        ack_vec;
  logic              cnt_done;

  rr_arb2 u_arb (
    .req_i        (bus_io.req),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt_d)
  );

  assign sel_addr_d = gnt_d[1] ? bus_io.req1_addr : bus_io.req0_addr;
  assign sel_data_d = gnt_d[1] ? bus_io.req1_data : bus_io.req0_data;
  assign en_dec     = EN_LSB << addr_q;
  assign ack_vec    = gnt_q ? 2'b10 : 2'b01;
  assign cnt_done   = (cnt_q == '0);

  // Every output is a flop so lat_en cannot glitch into the latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      lat_d_q      <= '0;
      lat_en_q     <= '0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
`ifdef LATCH_SCHED_READBACK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_d != 2'b00) begin
            addr_q       <= sel_addr_d;
            lat_d_q      <= sel_data_d;
            gnt_q        <= gnt_d[1];
            last_grant_q <= gnt_d[1];
            busy_q       <= 1'b1;
            cnt_q        <= CNT_W'(SETUP_CYC - 1);
            state_q      <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_done) begin
            cnt_q    <= CNT_W'(PULSE_CYC - 1);
            lat_en_q <= en_dec;
            state_q  <= PULSE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt_done) begin
            cnt_q    <= CNT_W'(HOLD_CYC - 1);
            lat_en_q <= '0;
            state_q  <= HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_done) begin
            cnt_q <= '0;
`ifdef LATCH_SCHED_READBACK_EN
            state_q <= VERIFY;
`else
            ack_q   <= ack_vec;
            state_q <= ACK;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef LATCH_SCHED_READBACK_EN
        VERIFY: begin
          err_q   <= (bus_io.lat_q != lat_d_q);
          ack_q   <= ack_vec;
          state_q <= ACK;
        end
`endif
        ACK: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef LATCH_SCHED_READBACK_EN
          err_q   <= 1'b0;
`endif
        end
        default: begin
          lat_en_q <= '0;
          ack_q    <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.ack    = ack_q;
  assign bus_io.busy   = busy_q;
  assign bus_io.lat_d  = lat_d_q;
  assign bus_io.lat_en = lat_en_q;
`ifdef LATCH_SCHED_READBACK_EN
  assign bus_io.lat_raddr = addr_q;
  assign bus_io.err       = err_q;
`endif

endmodule

// File: tb/tb_latch_write_sched.sv
// Directed bench for latch_write_sched: default-timing DUT with a behavioural latch bank,
// plus a stretched-timing DUT; readback checks when LATCH_SCHED_READBACK_EN is defined.
module tb_latch_write_sched;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef LATCH_SCHED_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  latch_sched_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  latch_sched_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus2 ();

  latch_write_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  latch_write_sched #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)
  ) dut2 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus2)
  );

  // Level-sensitive latch words: transparent while their enable is high.
  logic [WIDTH-1:0] bank [DEPTH];
  always @(bus.lat_en or bus.lat_d) begin
    for (int w = 0; w < DEPTH; w++) begin
      if (bus.lat_en[w]) bank[w] = bus.lat_d;
    end
  end

`ifdef LATCH_SCHED_READBACK_EN
  logic bad_rb = 1'b0;
  assign bus.lat_q  = bad_rb ? '0 : bank[bus.lat_raddr];
  assign bus2.lat_q = '0;
`endif

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int ack_who [$];
  int ack_at  [$];
  int ack_err [$];
  bit multi_en;

  task automatic do_reset();
    rst = 1'b1;
    bus.req  = 2'b00;
    bus2.req = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs cycles from the current cycle 0 until n_acks acks are seen, then drops all requests.
  task automatic serve(input int n_acks, input bit drop_each, input int budget);
    int c = 0;
    int got = 0;
    logic [1:0] drop;
    ack_who.delete();
    ack_at.delete();
    ack_err.delete();
    while (got < n_acks && c < budget) begin
      @(negedge clk);
      drop = 2'b00;
      if ($countones(bus.lat_en) > 1) multi_en = 1'b1;
      if (bus.ack != 2'b00) begin
        ack_who.push_back(int'(bus.ack[1]));
        ack_at.push_back(c);
`ifdef LATCH_SCHED_READBACK_EN
        ack_err.push_back(int'(bus.err));
`endif
        got++;
        if (drop_each) drop = bus.ack;
      end
      @(posedge clk);
      #1 bus.req = bus.req & ~drop;
      c++;
    end
    bus.req = 2'b00;
    check("serve_ack_count", got, n_acks);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    int n_ack;
    int en_cnt;
    int first_en;
    int ack_c;
    logic [DEPTH-1:0] en_val;

    bus.req = 2'b00;  bus.req0_addr = '0;  bus.req0_data = '0;
    bus.req1_addr = '0;  bus.req1_data = '0;
    bus2.req = 2'b00; bus2.req0_addr = '0; bus2.req0_data = '0;
    bus2.req1_addr = '0; bus2.req1_data = '0;
    multi_en = 1'b0;

    // Reset values while rst is held.
    @(negedge clk);
    check("rst_ack", bus.ack, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_lat_d", bus.lat_d, 8'h00);
    check("rst_lat_en", bus.lat_en, 4'b0000);
`ifdef LATCH_SCHED_READBACK_EN
    check("rst_err", bus.err, 1'b0);
    check("rst_raddr", bus.lat_raddr, 2'd0);
`endif

    // Test 1: lone requester 0, word 2 <- A5, cycle-exact enable and ack.
    do_reset();
    bus.req0_addr = 2'd2; bus.req0_data = 8'hA5; bus.req = 2'b01;
    for (int c = 0; c <= 5 + RB; c++) begin
      @(negedge clk);
      check($sformatf("t1_en_c%0d", c), bus.lat_en, (c == 2) ? 4'b0100 : 4'b0000);
      check($sformatf("t1_ack_c%0d", c), bus.ack, (c == 4 + RB) ? 2'b01 : 2'b00);
      if (c == 1) check("t1_lat_d", bus.lat_d, 8'hA5);
      if (c == 1) check("t1_busy", bus.busy, 1'b1);
      seen = bus.ack[0];
      @(posedge clk);
      #1 if (seen) bus.req = 2'b00;
    end
    check("t1_busy_idle", bus.busy, 1'b0);
    check("t1_word2", bank[2], 8'hA5);

    // Test 2: simultaneous requests after reset, requester 0 wins the first tie.
    do_reset();
    multi_en = 1'b0;
    bus.req0_addr = 2'd1; bus.req0_data = 8'h3C;
    bus.req1_addr = 2'd3; bus.req1_data = 8'hC3;
    bus.req = 2'b11;
    serve(2, 1'b1, 40);
    if (ack_who.size() == 2) begin
      check("t2_first", ack_who[0], 0);
      check("t2_second", ack_who[1], 1);
      check("t2_ack0_cyc", ack_at[0], 4 + RB);
      check("t2_ack1_cyc", ack_at[1], 9 + 2 * RB);
    end
    check("t2_word1", bank[1], 8'h3C);
    check("t2_word3", bank[3], 8'hC3);
    check("t2_onehot", multi_en, 1'b0);

    // Test 3: both held high for four writes, grants alternate.
    multi_en = 1'b0;
    bus.req0_addr = 2'd0; bus.req0_data = 8'h11;
    bus.req1_addr = 2'd2; bus.req1_data = 8'h22;
    bus.req = 2'b11;
    serve(4, 1'b0, 60);
    if (ack_who.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("t3_order%0d", i), ack_who[i], i % 2);
      for (int i = 1; i < 4; i++) check($sformatf("t3_gap%0d", i), ack_at[i] - ack_at[i-1], 5 + RB);
    end
    check("t3_onehot", multi_en, 1'b0);
    check("t3_word0", bank[0], 8'h11);
    check("t3_word2", bank[2], 8'h22);

    // Test 4: reset during PULSE clears lat_en at once and suppresses ack.
    do_reset();
    bus.req0_addr = 2'd0; bus.req0_data = 8'h5A; bus.req = 2'b01;
    repeat (3) @(negedge clk);
    check("t4_en_pulse", bus.lat_en, 4'b0001);
    #1 rst = 1'b1;
    #1;
    check("t4_en_async", bus.lat_en, 4'b0000);
    check("t4_busy_async", bus.busy, 1'b0);
    bus.req = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) n_ack++;
    end
    check("t4_no_ack", n_ack, 0);
    @(posedge clk);
    #1 bus.req0_data = 8'h96; bus.req = 2'b01;
    serve(1, 1'b1, 20);
    if (ack_at.size() == 1) check("t4_retry_ack_cyc", ack_at[0], 4 + RB);
    check("t4_word0", bank[0], 8'h96);

    // Test 5: stretched timing 2/3/2 on the second instance.
    do_reset();
    bus2.req0_addr = 2'd1; bus2.req0_data = 8'h77; bus2.req = 2'b01;
    en_cnt = 0; first_en = -1; ack_c = -1; en_val = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus2.lat_en != '0) begin
        en_cnt++;
        if (first_en < 0) begin
          first_en = c;
          en_val   = bus2.lat_en;
        end
      end
      seen = (bus2.ack != 2'b00);
      if (seen && ack_c < 0) ack_c = c;
      @(posedge clk);
      #1 if (seen) bus2.req = 2'b00;
    end
    check("t5_en_cycles", en_cnt, 3);
    check("t5_en_first", first_en, 3);
    check("t5_en_value", en_val, 4'b0010);
    check("t5_ack_cyc", ack_c, 8 + RB);

`ifdef LATCH_SCHED_READBACK_EN
    // Test 6: readback mismatch raises err with ack; clean readback keeps it low.
    do_reset();
    bad_rb = 1'b1;
    bus.req0_addr = 2'd3; bus.req0_data = 8'hFF; bus.req = 2'b01;
    serve(1, 1'b1, 20);
    if (ack_err.size() == 1) check("t6_err_bad", ack_err[0], 1);
    @(negedge clk);
    check("t6_err_clears", bus.err, 1'b0);
    @(posedge clk);
    #1 bad_rb = 1'b0; bus.req = 2'b01;
    serve(1, 1'b1, 20);
    if (ack_err.size() == 1) check("t6_err_good", ack_err[0], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
